// File: rtl/first_nios2_system_sysid_pkg.sv
// first_nios2_system_sysid_pkg
//   Shared definitions for the system ID checker: FSM state encoding,
//   slave word addresses, stall-timer width and a 32-bit compare helper.
package first_nios2_system_sysid_pkg;

  localparam int unsigned SYSID_TIMER_W = 8;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } sysid_state_e;

  // Full-width equality of a captured word against its build-time value.
  function automatic logic words_match(input logic [31:0] got, input logic [31:0] want);
    return (got == want);
  endfunction

endpackage

// File: rtl/first_nios2_system_avm_read_timer.sv
// first_nios2_system_avm_read_timer
//   Saturating stall counter for one Avalon read.
//   clock/reset : rising-edge clock, async active-high reset
//   clear       : zero the count (wins over enable)
//   enable      : count one stall cycle
//   expired     : count has reached LIMIT-1, i.e. this stall cycle is the last allowed
module first_nios2_system_avm_read_timer
  import first_nios2_system_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [SYSID_TIMER_W-1:0] LAST = SYSID_TIMER_W'(LIMIT - 1);

  logic [SYSID_TIMER_W-1:0] count_r;

  assign expired = (count_r == LAST);

  // Stall count; held at LAST so it can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {SYSID_TIMER_W{1'b0}};
    end else if (clear) begin
      count_r <= {SYSID_TIMER_W{1'b0}};
    end else if (enable && !expired) begin
      count_r <= count_r + {{(SYSID_TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker
//   Avalon-MM master that reads the system ID slave (ID at word 0, timestamp
//   at word 1), compares both with build-time values and reports the result.
//   clock, reset            : rising-edge clock, async active-high reset
//   start                   : check request pulse (honoured in IDLE or DONE)
//   avm_address/avm_read    : read request to the slave
//   avm_waitrequest/readdata: slave stall and zero-latency read data
//   busy/done/pass          : progress and overall verdict
//   id_ok/ts_ok/timeout     : per-word verdicts and hung-slave flag
//   read_id/read_ts         : captured words
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h00000007,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h526835B9,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  sysid_state_e state_r;
  logic         auto_pend_r;
  logic         start_accept_s;
  logic         reading_s;
  logic         timer_clear_s;
  logic         timer_enable_s;
  logic         timer_expired_s;

  // Start acceptance and stall-timer control.
  always_comb begin
    start_accept_s = 1'b0;
    reading_s      = 1'b0;
    if (state_r == ST_IDLE) begin
      start_accept_s = start | auto_pend_r;
    end else if (state_r == ST_DONE) begin
      start_accept_s = start;
    end else begin
      start_accept_s = 1'b0;
    end
    if ((state_r == ST_RD_ID) || (state_r == ST_RD_TS)) begin
      reading_s = 1'b1;
    end else begin
      reading_s = 1'b0;
    end
    timer_clear_s  = start_accept_s | (reading_s & ~avm_waitrequest);
    timer_enable_s = reading_s & avm_waitrequest;
  end

  first_nios2_system_avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear_s),
    .enable  (timer_enable_s),
    .expired (timer_expired_s)
  );

  // Check sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      auto_pend_r <= (AUTO_START != 0);
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= 32'h0000_0000;
      read_ts     <= 32'h0000_0000;
    end else begin
      // The automatic start only ever applies to the first cycle out of reset.
      auto_pend_r <= 1'b0;
      if (start_accept_s) begin
        state_r     <= ST_RD_ID;
        avm_read    <= 1'b1;
        avm_address <= SYSID_ADDR_ID;
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout     <= 1'b0;
        read_id     <= 32'h0000_0000;
        read_ts     <= 32'h0000_0000;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_RD_ID: begin
            if (!avm_waitrequest) begin
              read_id     <= avm_readdata;
              avm_address <= SYSID_ADDR_TS;
              state_r     <= ST_RD_TS;
            end else if (timer_expired_s) begin
              timeout  <= 1'b1;
              avm_read <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              state_r <= ST_RD_ID;
            end
          end
          ST_RD_TS: begin
            if (!avm_waitrequest) begin
              read_ts     <= avm_readdata;
              avm_read    <= 1'b0;
              avm_address <= SYSID_ADDR_ID;
              state_r     <= ST_CHECK;
            end else if (timer_expired_s) begin
              timeout     <= 1'b1;
              avm_read    <= 1'b0;
              avm_address <= SYSID_ADDR_ID;
              busy        <= 1'b0;
              done        <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_RD_TS;
            end
          end
          ST_CHECK: begin
            id_ok   <= words_match(read_id, EXPECTED_ID);
            ts_ok   <= words_match(read_ts, EXPECTED_TIMESTAMP);
            pass    <= words_match(read_id, EXPECTED_ID)
                     & words_match(read_ts, EXPECTED_TIMESTAMP) & ~timeout;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r     <= ST_IDLE;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb_first_nios2_system_sysid_checker
//   Directed and randomized checks of the system ID checker against a
//   transaction-level expectation model computed from stall counts.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0007;
  localparam logic [31:0] EXP_TS = 32'h5268_35B9;
  localparam int          T      = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T),
    .AUTO_START         (1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .read_id         (read_id),
    .read_ts         (read_ts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_avm_address"}, {31'd0, avm_address}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_id_ok"}, {31'd0, id_ok}, 32'd0);
    chk({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_read_id"}, read_id, 32'd0);
    chk({tag, "_read_ts"}, read_ts, 32'd0);
  endtask

  // One whole check. Called between a rising edge and the next one; the
  // start (or the automatic start) is taken at the next rising edge, which
  // makes the following cycle "cycle 1". sid/sts are the waitrequest stall
  // lengths of the ID and timestamp reads. ign_k pulses start during a busy
  // cycle, which must have no effect.
  task automatic run_check(input bit do_start, input logic [31:0] idv, input logic [31:0] tsv,
                           input int sid, input int sts, input int ign_k);
    bit to_id, to_ts, in_id, in_ts, fin;
    int id_end, ts_start, ts_end, done_k;
    bit exp_id_ok, exp_ts_ok;
    to_id    = (sid >= T);
    to_ts    = !to_id && (sts >= T);
    id_end   = to_id ? T : sid + 1;
    ts_start = id_end + 1;
    ts_end   = to_ts ? ts_start + T - 1 : ts_start + sts;
    if (to_id)      done_k = T + 1;
    else if (to_ts) done_k = ts_end + 1;
    else            done_k = ts_end + 2;
    exp_id_ok = !to_id && !to_ts && (idv == EXP_ID);
    exp_ts_ok = !to_id && !to_ts && (tsv == EXP_TS);
    if (do_start) start = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      @(posedge clock); #1;
      start = (k == ign_k);
      in_id = (k <= id_end);
      in_ts = !to_id && (k >= ts_start) && (k <= ts_end);
      if (in_id)      avm_waitrequest = (k <= sid);
      else if (in_ts) avm_waitrequest = ((k - ts_start) < sts);
      else            avm_waitrequest = 1'b1;
      if (in_id && !avm_waitrequest)      avm_readdata = idv;
      else if (in_ts && !avm_waitrequest) avm_readdata = tsv;
      else                                avm_readdata = $urandom;
      @(negedge clock);
      fin = (k == done_k);
      chk("avm_read", {31'd0, avm_read}, {31'd0, in_id | in_ts});
      if (in_id || in_ts) chk("avm_address", {31'd0, avm_address}, {31'd0, in_ts});
      chk("busy", {31'd0, busy}, {31'd0, !fin});
      chk("done", {31'd0, done}, {31'd0, fin});
      chk("read_id", read_id, (!to_id && k > id_end) ? idv : 32'd0);
      chk("read_ts", read_ts, (!to_id && !to_ts && k > ts_end) ? tsv : 32'd0);
      chk("timeout", {31'd0, timeout}, {31'd0, fin && (to_id || to_ts)});
      chk("pass", {31'd0, pass}, {31'd0, fin && exp_id_ok && exp_ts_ok});
      if (fin) begin
        chk("id_ok", {31'd0, id_ok}, {31'd0, exp_id_ok});
        chk("ts_ok", {31'd0, ts_ok}, {31'd0, exp_ts_ok});
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] idv, tsv;
    reset           = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_cleared("reset");

    // Automatic check straight out of reset against a matching slave.
    @(posedge clock); #1;
    reset = 1'b0;
    run_check(1'b0, EXP_ID, EXP_TS, 0, 0, 0);

    // Matching slave, explicit start from DONE.
    run_check(1'b1, EXP_ID, EXP_TS, 0, 0, 0);
    // Wrong ID.
    run_check(1'b1, 32'd8, EXP_TS, 0, 0, 0);
    // Wrong timestamp.
    run_check(1'b1, EXP_ID, 32'h5268_35B8, 0, 0, 0);
    // Three stall cycles on each read.
    run_check(1'b1, EXP_ID, EXP_TS, 3, 3, 0);
    // Longest stall that still completes.
    run_check(1'b1, EXP_ID, EXP_TS, T - 1, T - 1, 0);
    // Stuck slave on the ID read, then on the timestamp read.
    run_check(1'b1, EXP_ID, EXP_TS, 50, 0, 0);
    run_check(1'b1, EXP_ID, EXP_TS, 1, 50, 0);
    // start during RD_TS is ignored; next start from DONE re-runs.
    run_check(1'b1, EXP_ID, EXP_TS, 0, 2, 3);
    run_check(1'b1, EXP_ID, EXP_TS, 0, 0, 0);

    // Reset in the middle of the timestamp read.
    start = 1'b1;
    @(posedge clock); #1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = EXP_ID;
    @(posedge clock); #1;
    avm_waitrequest = 1'b1;
    @(negedge clock);
    chk("midrst_pre_read", {31'd0, avm_read}, 32'd1);
    chk("midrst_pre_addr", {31'd0, avm_address}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_cleared("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    run_check(1'b0, EXP_ID, EXP_TS, 0, 1, 0);

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      idv = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      tsv = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      run_check(1'b1, idv, tsv, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
